// File: rtl/gol_run_controller.sv
// gol_run_controller: sequencer for a 3x3 Game-of-Life grid.
// Accepts a seed and generation limit, loads the grid, lets it evolve one
// generation per clock until a stop condition, then reports the outcome.
// Optional period-2 oscillation detection: define GOL_CTRL_OSC_DETECT_EN.
module gol_run_controller #(
  parameter int GEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [8:0]       pattern,
  input  logic [GEN_W-1:0] gen_limit,
  input  logic             abort,
  input  logic [8:0]       grid_out,
  output logic [8:0]       grid_in,
  output logic             grid_init,
  output logic             busy,
  output logic             done,
  output logic [2:0]       status,
  output logic [GEN_W-1:0] gen_count,
  output logic [8:0]       result_grid
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  localparam logic [2:0] ST_LIMIT   = 3'd0;
  localparam logic [2:0] ST_STABLE  = 3'd1;
  localparam logic [2:0] ST_EXTINCT = 3'd2;
  localparam logic [2:0] ST_ABORTED = 3'd3;
`ifdef GOL_CTRL_OSC_DETECT_EN
  localparam logic [2:0] ST_OSC     = 3'd4;
`endif

  state_t           state_q, state_d;
  logic [8:0]       pat_q, pat_d;
  logic [GEN_W-1:0] lim_q, lim_d;
  logic [8:0]       prev_q, prev_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic [2:0]       status_q, status_d;
  logic [8:0]       result_q, result_d;
`ifdef GOL_CTRL_OSC_DETECT_EN
  logic [8:0]       prev2_q, prev2_d;
`endif

  // stop decision for the current RUN cycle, first match wins
  logic       stop;
  logic [2:0] code;

  // Priority-ordered stop checks against the generation currently on grid_out
  always_comb begin
    stop = 1'b1;
    code = ST_LIMIT;
    if (abort)                                         code = ST_ABORTED;
    else if (grid_out == 9'd0)                         code = ST_EXTINCT;
    else if (gen_q != '0 && grid_out == prev_q)        code = ST_STABLE;
`ifdef GOL_CTRL_OSC_DETECT_EN
    else if (gen_q >= GEN_W'(2) && grid_out == prev2_q) code = ST_OSC;
`endif
    else if (gen_q == lim_q)                           code = ST_LIMIT;
    else                                               stop = 1'b0;
  end

  // Next-state and output logic; grid is frozen (reloaded with itself) unless advancing
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    lim_d       = lim_q;
    prev_d      = prev_q;
    gen_d       = gen_q;
    status_d    = status_q;
    result_d    = result_q;
`ifdef GOL_CTRL_OSC_DETECT_EN
    prev2_d     = prev2_q;
`endif
    start_ready = 1'b0;
    grid_init   = 1'b1;
    grid_in     = grid_out;
    busy        = (state_q != S_IDLE);
    done        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          pat_d   = pattern;
          lim_d   = gen_limit;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        grid_in = pat_q;
        gen_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (stop) begin
          status_d = code;
          result_d = grid_out;
          state_d  = S_DONE;
        end else begin
          grid_init = 1'b0;
          prev_d    = grid_out;
          gen_d     = gen_q + GEN_W'(1);
`ifdef GOL_CTRL_OSC_DETECT_EN
          prev2_d   = prev_q;
`endif
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pat_q    <= '0;
      lim_q    <= '0;
      prev_q   <= '0;
      gen_q    <= '0;
      status_q <= '0;
      result_q <= '0;
`ifdef GOL_CTRL_OSC_DETECT_EN
      prev2_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      lim_q    <= lim_d;
      prev_q   <= prev_d;
      gen_q    <= gen_d;
      status_q <= status_d;
      result_q <= result_d;
`ifdef GOL_CTRL_OSC_DETECT_EN
      prev2_q  <= prev2_d;
`endif
    end
  end

  assign status      = status_q;
  assign gen_count   = gen_q;
  assign result_grid = result_q;

endmodule

// File: doc/gol_run_controller.md
Name: gol_run_controller

Overview:
- Sequencer for the 3x3 Game-of-Life grid.
- Accepts a seed pattern and generation limit over a valid/ready handshake, then loads the grid through its initialise path.
- Lets the grid evolve one generation per clock until a stop condition, then reports status, generation count and final pattern.
- Freezes the grid when not running by asserting initialise with the grid's own output fed back as the load value.

Parameters:
- GEN_W, 8, width of generation limit and generation counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_valid  input  1  new run requested.
- start_ready  output  1  controller can accept a run.
- pattern  input  9  seed grid; cell (r,c) is bit r*3+c.
- gen_limit  input  GEN_W  maximum generations to apply.
- abort  input  1  stop the current run.
- grid_out  input  9  current grid state from grid outputs, same bit mapping.
- grid_in  output  9  load value driven to grid inputs.
- grid_init  output  1  grid initialise; 1 = load grid_in on this edge, 0 = advance one generation.
- busy  output  1  run in progress (LOAD/RUN/DONE).
- done  output  1  one-cycle pulse at run end.
- status  output  3  0 LIMIT, 1 STABLE, 2 EXTINCT, 3 ABORTED, 4 OSCILLATING.
- gen_count  output  GEN_W  generations applied in current/last run.
- result_grid  output  9  grid at run end.

Behaviour:
- Reset (async, rst_n low): state IDLE; busy=0, done=0, status=0, gen_count=0, result_grid=0; internal pattern/limit/prev registers cleared. grid_init=1 and grid_in=grid_out while in reset.
- States: IDLE, LOAD, RUN, DONE.
- IDLE: start_ready=1, grid_init=1, grid_in=grid_out (hold). On start_valid=1, latch pattern and gen_limit, then go to LOAD. status and result_grid keep last values.
- LOAD (1 cycle): start_ready=0, grid_init=1, grid_in=latched pattern. Clear gen_count, then go to RUN.
- RUN: let k=gen_count; grid_out holds generation k. Stop checks are combinational (Mealy) on the current cycle, first match wins:
  - abort=1 → ABORTED.
  - grid_out==0 → EXTINCT.
  - k>0 and grid_out==prev → STABLE.
  - k==gen_limit → LIMIT.
  - Otherwise: grid_init=0, prev<=grid_out, gen_count<=k+1, stay in RUN.
- On stop: grid_init=1, grid_in=grid_out (grid frozen on that edge); status<=code, result_grid<=grid_out; go to DONE; gen_count unchanged.
- DONE (1 cycle): done=1, busy=1, grid held; then go to IDLE.
- Latency: handshake edge → LOAD 1 cycle → RUN for (stop generation + 1) cycles → DONE 1 cycle.
- start_valid while busy: ignored; start_ready=0 outside IDLE.
- abort outside RUN: ignored.
- gen_limit=0: stops in first RUN cycle with LIMIT unless extinct; gen_count=0.
- gen_count never wraps, bounded by gen_limit ≤ 2^GEN_W-1.
- Reset mid-run: immediate return to IDLE with all reset values; no done pulse.

Optional Feature:
- Macro GOL_CTRL_OSC_DETECT_EN.
- With macro: keep a second history register prev2 (prev2<=prev on each advance). In RUN, after the STABLE check and before the LIMIT check: k≥2 and grid_out==prev2 → OSCILLATING (code 4).
- Without macro: prev2 absent, code 4 never produced, period-2 patterns run to LIMIT.

Test Plan:
- Block pattern 9'h01B, limit 10 → RUN k=0 advances; k=1 grid_out==prev → done with status=1 STABLE, gen_count=1, result_grid=9'h01B.
- Centre cell 9'h010, limit 5 → k=1 grid_out=0 → status=2 EXTINCT, gen_count=1, result_grid=0.
- Blinker 9'h092, limit 6, macro off → alternates 9'h038/9'h092 → status=0 LIMIT, gen_count=6, result_grid=9'h092. Macro on → status=4, gen_count=2, result_grid=9'h092.
- Pattern 9'h092, limit 0 → exactly 4 cycles from handshake edge to done (IDLE accept, LOAD, RUN, DONE) → status=0, gen_count=0, result_grid=9'h092, grid_init never 0.
- Blinker, limit 200, abort pulse at k=3; start_valid held during run → status=3, gen_count=3, result_grid=9'h038; second start not accepted until start_ready=1 in IDLE.
- rst_n low at k=4 of a 9'h092 run → same cycle: busy=0, done=0, status=0, gen_count=0, start_ready=1, grid_init=1; no done pulse.
